// File: rtl/core_pipe_ctrl_if.sv
// Handshake bundle between the pipeline stage modules and core_pipe_ctrl.
// Perf counter lines are meaningful only when CORE_PIPE_PERF_EN is defined.
interface core_pipe_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned FW_W = $clog2(STAGES - 2);

  logic              dec_val;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              dec_rs1_use;
  logic              dec_rs2_use;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_we;
  logic              dec_ld;
  logic              if_wait;
  logic              mem_wait;
  logic              exe_brnch_tkn;

  logic [STAGES-2:0] pipe_enb;
  logic [STAGES-2:0] pipe_kill;
  logic              pc_hold;
  logic              pc_redirect;
  logic [FW_W-1:0]   fwd_sel_rs1;
  logic [FW_W-1:0]   fwd_sel_rs2;
  logic              retire;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output dec_val, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use, dec_rd,
           dec_we, dec_ld, if_wait, mem_wait, exe_brnch_tkn,
    input  pipe_enb, pipe_kill, pc_hold, pc_redirect, fwd_sel_rs1,
           fwd_sel_rs2, retire, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  dec_val, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use, dec_rd,
           dec_we, dec_ld, if_wait, mem_wait, exe_brnch_tkn,
    output pipe_enb, pipe_kill, pc_hold, pc_redirect, fwd_sel_rs1,
           fwd_sel_rs2, retire, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/core_pipe_ctrl.sv
// Pipeline hazard/stall/flush/bypass control for an N-stage in-order core.
// Optional stall/flush counters are built when CORE_PIPE_PERF_EN is defined.
module core_pipe_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned REG_AW = 5
) (
  input logic           clk,
  input logic           rst,
  core_pipe_ctrl_if.slave pipe_if
);
  localparam int unsigned FW_W = $clog2(STAGES - 2);

  typedef struct packed {
    logic              val;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_use;
    logic              rs2_use;
  } sb_t;

  typedef enum logic [2:0] {
    ACT_RUN,
    ACT_RST,
    ACT_MEMW,
    ACT_BRANCH,
    ACT_LDUSE,
    ACT_IFW
  } act_e;

  sb_t sb_q [2:STAGES-1];
  sb_t sb_d [2:STAGES-1];

  act_e              act;
  logic              ld_use;
  logic [STAGES-2:0] enb;
  logic [STAGES-2:0] kill;
  logic              hold;
  logic              redir;
  logic [FW_W-1:0]   fwd1;
  logic [FW_W-1:0]   fwd2;

  // Loads only become forwardable once they sit in WB.
  function automatic logic fwd_hit(input int unsigned s, input logic [REG_AW-1:0] rs);
    return sb_q[s].val && sb_q[s].we && (sb_q[s].rd == rs) &&
           (!sb_q[s].ld || (s == STAGES - 1));
  endfunction

  always_comb begin
    ld_use = 1'b0;
    for (int unsigned s = 2; s <= STAGES - 2; s++) begin
      if (sb_q[s].val && sb_q[s].we && sb_q[s].ld && (sb_q[s].rd != '0) &&
          ((pipe_if.dec_rs1_use && (pipe_if.dec_rs1 == sb_q[s].rd)) ||
           (pipe_if.dec_rs2_use && (pipe_if.dec_rs2 == sb_q[s].rd))))
        ld_use = 1'b1;
    end
    ld_use = ld_use & pipe_if.dec_val;
  end

  always_comb begin
    if (rst)                                        act = ACT_RST;
    else if (pipe_if.mem_wait)                      act = ACT_MEMW;
    else if (pipe_if.exe_brnch_tkn && sb_q[2].val)  act = ACT_BRANCH;
    else if (ld_use)                                act = ACT_LDUSE;
    else if (pipe_if.if_wait)                       act = ACT_IFW;
    else                                            act = ACT_RUN;
  end

  always_comb begin
    enb   = '1;
    kill  = '0;
    hold  = 1'b0;
    redir = 1'b0;
    unique case (act)
      ACT_RST: begin
        enb  = '0;
        kill = '1;
        hold = 1'b1;
      end
      ACT_MEMW: begin
        enb               = '0;
        enb[STAGES-2]     = 1'b1;
        kill[STAGES-2]    = 1'b1;
        hold              = 1'b1;
      end
      ACT_BRANCH: begin
        kill[1:0] = 2'b11;
        redir     = 1'b1;
      end
      ACT_LDUSE: begin
        enb[0]  = 1'b0;
        kill[1] = 1'b1;
        hold    = 1'b1;
      end
      ACT_IFW: begin
        kill[0] = 1'b1;
        hold    = 1'b1;
      end
      default: ;
    endcase
  end

  // Walk oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    if (!rst) begin
      for (int unsigned k = STAGES - 3; k >= 1; k--) begin
        if (sb_q[2].rs1_use && (sb_q[2].rs1 != '0) && fwd_hit(k + 2, sb_q[2].rs1))
          fwd1 = FW_W'(k);
        if (sb_q[2].rs2_use && (sb_q[2].rs2 != '0) && fwd_hit(k + 2, sb_q[2].rs2))
          fwd2 = FW_W'(k);
      end
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (enb[1]) begin
      sb_d[2].val     = pipe_if.dec_val & ~kill[1];
      sb_d[2].rd      = pipe_if.dec_rd;
      sb_d[2].we      = pipe_if.dec_we;
      sb_d[2].ld      = pipe_if.dec_ld;
      sb_d[2].rs1     = pipe_if.dec_rs1;
      sb_d[2].rs2     = pipe_if.dec_rs2;
      sb_d[2].rs1_use = pipe_if.dec_rs1_use;
      sb_d[2].rs2_use = pipe_if.dec_rs2_use;
    end
    for (int unsigned s = 3; s <= STAGES - 1; s++) begin
      if (enb[s-1]) begin
        sb_d[s] = sb_q[s-1];
        if (kill[s-1])
          sb_d[s].val = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '{default: '0};
    else     sb_q <= sb_d;
  end

  assign pipe_if.pipe_enb    = enb;
  assign pipe_if.pipe_kill   = kill;
  assign pipe_if.pc_hold     = hold;
  assign pipe_if.pc_redirect = redir;
  assign pipe_if.fwd_sel_rs1 = fwd1;
  assign pipe_if.fwd_sel_rs2 = fwd2;
  assign pipe_if.retire      = (act != ACT_RST) && sb_q[STAGES-1].val && !pipe_if.mem_wait;

`ifdef CORE_PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_evt;

  assign stall_evt = (act == ACT_MEMW) || (act == ACT_LDUSE) || (act == ACT_IFW);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign pipe_if.perf_stall_cnt = stall_cnt_q;
  assign pipe_if.perf_flush_cnt = flush_cnt_q;
`else
  assign pipe_if.perf_stall_cnt = '0;
  assign pipe_if.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Self-checking bench for core_pipe_ctrl: directed hazard scenarios plus random
// traffic, compared against a stage-occupancy reference model.
module tb_core_pipe_ctrl;
  localparam int unsigned STAGES = 7;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned FW_W   = $clog2(STAGES - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_pipe_ctrl_if #(.STAGES(STAGES), .REG_AW(REG_AW)) pif ();
  core_pipe_ctrl #(.STAGES(STAGES), .REG_AW(REG_AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_if (pif)
  );

  typedef struct {
    bit          v;
    int unsigned rd, rs1, rs2;
    bit          we, ld, u1, u2;
  } ins_t;

  ins_t            pipe [STAGES];
  longint unsigned m_stall = 0;
  longint unsigned m_flush = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned fwd_ref(input int unsigned rs, input bit u);
    if (!u || rs == 0) return 0;
    for (int s = 3; s < STAGES; s++)
      if (pipe[s].v && pipe[s].we && pipe[s].rd == rs && (!pipe[s].ld || s == STAGES - 1))
        return s - 2;
    return 0;
  endfunction

  task automatic step(input bit r, input bit dv, input int unsigned rd, rs1, rs2,
                      input bit u1, u2, we, ld, ifw, memw, br);
    logic [STAGES-2:0] e_enb, e_kill;
    bit e_hold, e_redir, e_ret, stall, lu;
    int unsigned frozen_below, e_f1, e_f2;
    longint unsigned e_ps, e_pf;

    @(negedge clk);
    rst               = r;
    pif.dec_val       = dv;
    pif.dec_rd        = REG_AW'(rd);
    pif.dec_rs1       = REG_AW'(rs1);
    pif.dec_rs2       = REG_AW'(rs2);
    pif.dec_rs1_use   = u1;
    pif.dec_rs2_use   = u2;
    pif.dec_we        = we;
    pif.dec_ld        = ld;
    pif.if_wait       = ifw;
    pif.mem_wait      = memw;
    pif.exe_brnch_tkn = br;
    #1;

    // Registers below frozen_below hold; bubbles enter where e_kill is set.
    frozen_below = 0; e_kill = '0; e_hold = 0; e_redir = 0; stall = 0;
    lu = 0;
    if (dv)
      for (int s = 2; s <= STAGES - 2; s++)
        if (pipe[s].v && pipe[s].we && pipe[s].ld && pipe[s].rd != 0 &&
            ((u1 && rs1 == pipe[s].rd) || (u2 && rs2 == pipe[s].rd)))
          lu = 1;
    if (r) begin
      frozen_below = STAGES - 1; e_kill = '1; e_hold = 1;
    end else if (memw) begin
      frozen_below = STAGES - 2; e_kill[STAGES-2] = 1'b1; e_hold = 1; stall = 1;
    end else if (br && pipe[2].v) begin
      e_kill[1:0] = 2'b11; e_redir = 1;
    end else if (lu) begin
      frozen_below = 1; e_kill[1] = 1'b1; e_hold = 1; stall = 1;
    end else if (ifw) begin
      e_kill[0] = 1'b1; e_hold = 1; stall = 1;
    end
    for (int i = 0; i <= STAGES - 2; i++) e_enb[i] = (i >= frozen_below);
    e_f1  = r ? 0 : fwd_ref(pipe[2].rs1, pipe[2].u1);
    e_f2  = r ? 0 : fwd_ref(pipe[2].rs2, pipe[2].u2);
    e_ret = !r && pipe[STAGES-1].v && !memw;
`ifdef CORE_PIPE_PERF_EN
    e_ps = m_stall; e_pf = m_flush;
`else
    e_ps = 0; e_pf = 0;
`endif

    check("pipe_enb",    64'(pif.pipe_enb),    64'(e_enb));
    check("pipe_kill",   64'(pif.pipe_kill),   64'(e_kill));
    check("pc_hold",     64'(pif.pc_hold),     64'(e_hold));
    check("pc_redirect", 64'(pif.pc_redirect), 64'(e_redir));
    check("fwd_sel_rs1", 64'(pif.fwd_sel_rs1), 64'(e_f1));
    check("fwd_sel_rs2", 64'(pif.fwd_sel_rs2), 64'(e_f2));
    check("retire",      64'(pif.retire),      64'(e_ret));
    check("perf_stall",  64'(pif.perf_stall_cnt), e_ps);
    check("perf_flush",  64'(pif.perf_flush_cnt), e_pf);

    @(posedge clk);
    cyc++;
    if (r) begin
      for (int s = 0; s < STAGES; s++) pipe[s].v = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_redir && m_flush < 64'hFFFF_FFFF) m_flush++;
      for (int s = STAGES - 1; s >= 3; s--)
        if (e_enb[s-1]) begin
          pipe[s] = pipe[s-1];
          if (e_kill[s-1]) pipe[s].v = 0;
        end
      if (e_enb[1])
        pipe[2] = '{v: dv && !e_kill[1], rd: rd, rs1: rs1, rs2: rs2,
                    we: we, ld: ld, u1: u1, u2: u2};
    end
  endtask

  task automatic op(input int unsigned rd, rs1, rs2, input bit ld,
                    input bit ifw, memw, br);
    step(0, 1, rd, rs1, rs2, 1, 1, 1, ld, ifw, memw, br);
  endtask

  task automatic idle(input int n, input bit memw, input bit br);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, memw, br);
  endtask

  initial begin
    rst = 1'b1;
    pif.dec_val = 0; pif.dec_rd = '0; pif.dec_rs1 = '0; pif.dec_rs2 = '0;
    pif.dec_rs1_use = 0; pif.dec_rs2_use = 0; pif.dec_we = 0; pif.dec_ld = 0;
    pif.if_wait = 0; pif.mem_wait = 0; pif.exe_brnch_tkn = 0;
    @(posedge clk);

    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Free-running independent ALU stream.
    for (int i = 0; i < 10; i++) op(10 + (i % 8), 20, 21, 0, 0, 0, 0);

    // Load x5 followed by a dependent add held in DEC until it may issue.
    op(5, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) op(6, 5, 1, 0, 0, 0, 0);
    idle(STAGES, 0, 0);

    // Back-to-back ALU dependency, then an x0 producer feeding x0 readers.
    op(3, 1, 2, 0, 0, 0, 0);
    op(4, 3, 3, 0, 0, 0, 0);
    op(0, 1, 2, 0, 0, 0, 0);
    op(7, 0, 0, 0, 0, 0, 0);
    idle(STAGES, 0, 0);

    // Taken branch frozen under a 3-cycle mem_wait.
    op(8, 1, 2, 0, 0, 0, 0);
    idle(3, 1, 1);
    idle(1, 0, 1);
    idle(STAGES, 0, 0);

    // Load two slots ahead of its consumer.
    op(9, 1, 2, 1, 0, 0, 0);
    op(11, 1, 2, 0, 0, 0, 0);
    op(12, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) op(13, 9, 2, 0, 0, 0, 0);
    idle(STAGES, 0, 0);

    // Reset while mem_wait stalls a full pipe.
    for (int i = 0; i < STAGES; i++) op(14, 1, 2, 0, 0, 0, 0);
    idle(2, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(STAGES, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(99) < 1, $urandom_range(99) < 70,
           $urandom_range(3), $urandom_range(3), $urandom_range(3),
           $urandom_range(1), $urandom_range(1), $urandom_range(99) < 70,
           $urandom_range(99) < 30, $urandom_range(99) < 15,
           $urandom_range(99) < 10, $urandom_range(99) < 12);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
